bec_key_sequencer: RTL and testbench

- Control and data stage that sits between the Wishbone/LA front-end and the binary-Edwards-curve ladder core.
- Upstream role: assembles the 163-bit scalar from 32-bit writes, asserts the core enable, and serialises the scalar MSB-first onto ki. It advances one bit on each next_key pulse from the core.
- Downstream role: on core done, captures wout/zout into result registers, readable as 32-bit words, and raises a one-cycle interrupt pulse.

---
 rtl/bec_key_sequencer.sv | 167 ++++++++++++++++
 tb/tb_bec_key_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bec_key_sequencer.sv
// Scalar sequencer for the binary-Edwards-curve ladder core: loads the key, streams it
// MSB-first on ki, captures the W/Z results on completion and exposes them as 32-bit words.
module bec_key_sequencer #(
  parameter int KEY_BITS = 163,
  parameter int WORDS    = 6,
  parameter int TIMEOUT  = 4096
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wr_en,
  input  logic [2:0]          wr_addr,
  input  logic [31:0]         wr_data,
  input  logic                start,
  input  logic                abort,
  input  logic [3:0]          rd_addr,
  output logic [31:0]         rd_data,
  output logic                busy,
  output logic                result_valid,
  output logic                err,
  output logic                irq,
  output logic                core_ena,
  output logic                ki,
  input  logic                next_key,
  input  logic                core_done,
  input  logic [KEY_BITS-1:0] wout,
  input  logic [KEY_BITS-1:0] zout
);

  localparam int IDX_W = $clog2(KEY_BITS);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [2:0]       WORDS_A = 3'(WORDS);
  localparam logic [3:0]       RD_Z0   = 4'(WORDS);
  localparam logic [3:0]       RD_END  = 4'(2 * WORDS);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(KEY_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_DONE} state_t;

  state_t              state_q, state_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [KEY_BITS-1:0] w_q, z_q;
  logic [IDX_W-1:0]    bit_idx_q;
  logic [CNT_W-1:0]    tmo_cnt_q;
  logic [31:0]         rd_word;
  logic                wr_ok;
  logic                do_start, do_abort, do_done, done_err, do_step, do_last, do_tmo;

  // Word idx of a result value; the top word is naturally zero-padded above KEY_BITS.
  function automatic logic [31:0] word_of(input logic [KEY_BITS-1:0] v, input logic [2:0] idx);
    return 32'(v >> (32 * idx));
  endfunction

  assign busy  = (state_q != IDLE);
  assign ki    = (state_q == RUN) ? key_q[bit_idx_q] : 1'b0;
  assign wr_ok = (state_q == IDLE) && wr_en && (wr_addr < WORDS_A);

  // Word 5 shifts past the key MSB, so wr_data[31:3] falls off the top.
  always_comb begin
    key_d = (key_q & ~(KEY_BITS'(32'hFFFF_FFFF) << (32 * wr_addr)))
          | (KEY_BITS'(wr_data) << (32 * wr_addr));
  end

  always_comb begin
    rd_word = '0;
    if (rd_addr < RD_Z0)
      rd_word = word_of(w_q, rd_addr[2:0]);
    else if (rd_addr < RD_END)
      rd_word = word_of(z_q, 3'(rd_addr - RD_Z0));
  end

  // Event decode in priority order: abort > core_done > next_key > timeout.
  always_comb begin
    state_d  = state_q;
    do_start = 1'b0;
    do_abort = 1'b0;
    do_done  = 1'b0;
    done_err = 1'b0;
    do_step  = 1'b0;
    do_last  = 1'b0;
    do_tmo   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          do_start = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d  = IDLE;
          do_abort = 1'b1;
        end else if (core_done) begin
          state_d  = IDLE;
          do_done  = 1'b1;
          done_err = !(next_key && (bit_idx_q == '0));
        end else if (next_key) begin
          if (bit_idx_q == '0) begin
            state_d = WAIT_DONE;
            do_last = 1'b1;
          end else begin
            do_step = 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (abort) begin
          state_d  = IDLE;
          do_abort = 1'b1;
        end else if (core_done) begin
          state_d = IDLE;
          do_done = 1'b1;
        end else if (tmo_cnt_q == CNT_END) begin
          state_d = IDLE;
          do_tmo  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      key_q        <= '0;
      w_q          <= '0;
      z_q          <= '0;
      bit_idx_q    <= IDX_TOP;
      tmo_cnt_q    <= '0;
      core_ena     <= 1'b0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      irq          <= 1'b0;
      rd_data      <= '0;
    end else begin
      state_q <= state_d;
      irq     <= do_done;
      rd_data <= rd_word;
      if (wr_ok)
        key_q <= key_d;
      if (wr_ok || do_start)
        result_valid <= 1'b0;
      if (do_start) begin
        core_ena  <= 1'b1;
        bit_idx_q <= IDX_TOP;
        err       <= 1'b0;
      end
      if (do_step)
        bit_idx_q <= bit_idx_q - 1'b1;
      if (do_last)
        tmo_cnt_q <= '0;
      else if (state_q == WAIT_DONE)
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (do_abort || do_done || do_tmo) begin
        core_ena  <= 1'b0;
        bit_idx_q <= IDX_TOP;
      end
      if (do_done) begin
        w_q          <= wout;
        z_q          <= zout;
        result_valid <= 1'b1;
      end
      if ((do_done && done_err) || do_tmo)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bec_key_sequencer.sv
// Randomized lockstep bench for bec_key_sequencer against a bit-count reference model.
module tb_bec_key_sequencer;
  localparam int KB = 163;
  localparam int TO = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [3:0]    rd_addr = '0;
  logic [31:0]   rd_data;
  logic          busy, result_valid, err, irq, core_ena, ki;
  logic          next_key = 1'b0;
  logic          core_done = 1'b0;
  logic [KB-1:0] wout = '0;
  logic [KB-1:0] zout = '0;

  always #5 clk = ~clk;

  bec_key_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .result_valid(result_valid), .err(err), .irq(irq), .core_ena(core_ena), .ki(ki),
    .next_key(next_key), .core_done(core_done), .wout(wout), .zout(zout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit rd_rand  = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 streaming bits, 2 waiting for the core.
  logic [KB-1:0] m_key = '0, m_w = '0, m_z = '0;
  int            m_mode = 0, m_used = 0, m_wait = 0;
  bit            m_valid = 0, m_err = 0, m_irq = 0;
  logic [31:0]   m_rd = '0;

  function automatic logic [31:0] m_word(input logic [KB-1:0] v, input int idx);
    logic [KB-1:0] s;
    s = v >> (32 * idx);
    return s[31:0];
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a < 6)  return m_word(m_w, a);
    if (a < 12) return m_word(m_z, a - 6);
    return 32'h0;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_key = '0; m_w = '0; m_z = '0; m_mode = 0; m_used = 0; m_wait = 0;
      m_valid = 0; m_err = 0; m_irq = 0; m_rd = '0;
      return;
    end
    m_rd  = m_read(int'(rd_addr));
    m_irq = 0;
    if (m_mode == 0) begin
      if (wr_en && wr_addr < 3'd6) begin
        for (int b = 0; b < 32; b++)
          if (32 * int'(wr_addr) + b < KB) m_key[32 * int'(wr_addr) + b] = wr_data[b];
        m_valid = 0;
      end
      if (start) begin
        m_mode = 1; m_used = 0; m_valid = 0; m_err = 0;
      end
    end else if (abort) begin
      m_mode = 0;
    end else if (core_done) begin
      m_w = wout; m_z = zout; m_valid = 1; m_irq = 1;
      if (m_mode == 1 && !(next_key && m_used == KB - 1)) m_err = 1;
      m_mode = 0;
    end else if (m_mode == 1 && next_key) begin
      m_used++;
      if (m_used == KB) begin
        m_mode = 2; m_wait = 0;
      end
    end else if (m_mode == 2) begin
      m_wait++;
      if (m_wait == TO) begin
        m_err = 1; m_mode = 0;
      end
    end
  endtask

  task automatic step();
    logic m_ki;
    @(posedge clk);
    model_edge();
    #1;
    m_ki = (m_mode == 1) ? m_key[KB - 1 - m_used] : 1'b0;
    check("core_ena", 32'(core_ena), 32'(m_mode != 0));
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("ki", 32'(ki), 32'(m_ki));
    check("irq", 32'(irq), 32'(m_irq));
    check("err", 32'(err), 32'(m_err));
    check("result_valid", 32'(result_valid), 32'(m_valid));
    check("rd_data", rd_data, m_rd);
    wr_en = 0; start = 0; abort = 0; next_key = 0; core_done = 0;
    if (rd_rand) rd_addr = 4'($urandom_range(0, 15));
  endtask

  function automatic logic [KB-1:0] rand163();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic write_word(input int a, input logic [31:0] d);
    wr_en = 1; wr_addr = 3'(a); wr_data = d;
    step();
  endtask

  task automatic load_key(input logic [KB-1:0] k);
    for (int i = 0; i < 6; i++) write_word(i, m_word(k, i) | (i == 5 ? $urandom & 32'hFFFF_FFF8 : 32'h0));
  endtask

  task automatic pulse_start();
    start = 1;
    step();
  endtask

  task automatic run_bits(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      for (int g = $urandom_range(0, maxgap); g > 0; g--) step();
      next_key = 1;
      step();
    end
  endtask

  task automatic finish_done(input logic [KB-1:0] w, input logic [KB-1:0] z);
    wout = w; zout = z; core_done = 1;
    step();
    step();
  endtask

  initial begin
    logic [KB-1:0] k, z;
    int n;
    step(); step();
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_core_ena", 32'(core_ena), 32'h0);
    rst = 0;
    step();

    // All-ones key, slow pulses, extra next_key in WAIT_DONE, unit results.
    for (int i = 0; i < 5; i++) write_word(i, 32'hFFFF_FFFF);
    write_word(5, 32'h0000_0007);
    pulse_start();
    check("ki_first", 32'(ki), 32'h1);
    run_bits(KB, 2);
    step(); step();
    next_key = 1; step();
    wout = 1; zout = 1; core_done = 1;
    step();
    check("irq_pulse", 32'(irq), 32'h1);
    step();
    check("irq_once", 32'(irq), 32'h0);
    rd_rand = 0;
    rd_addr = 4'd0; step();
    check("rd_w0", rd_data, 32'h1);
    rd_addr = 4'd6; step();
    check("rd_z0", rd_data, 32'h1);
    rd_rand = 1;

    // Key = 1, back-to-back pulses.
    k = '0; k[0] = 1'b1;
    load_key(k);
    pulse_start();
    run_bits(KB, 0);
    step();
    finish_done(rand163(), rand163());

    // Early core_done flags an error but still captures.
    load_key(rand163());
    pulse_start();
    run_bits(10, 1);
    wout = rand163(); zout = rand163(); core_done = 1;
    step();
    check("err_early", 32'(err), 32'h1);
    check("valid_early", 32'(result_valid), 32'h1);
    step();

    // Timeout with no core_done, then a fresh start clears err.
    load_key(rand163());
    pulse_start();
    run_bits(KB, 0);
    for (int c = 0; c < TO + 8 && busy; c++) step();
    check("timeout_idle", 32'(busy), 32'h0);
    check("timeout_err", 32'(err), 32'h1);
    pulse_start();
    check("err_cleared", 32'(err), 32'h0);
    abort = 1; step();

    // Abort at bit_idx 100; writes and start during the run must not disturb the key.
    load_key(rand163());
    pulse_start();
    wr_en = 1; wr_addr = 3'd0; wr_data = $urandom; start = 1;
    step();
    run_bits(KB - 1 - 100, 1);
    wr_en = 1; wr_addr = 3'd3; wr_data = $urandom;
    step();
    abort = 1; step();
    check("abort_ena", 32'(core_ena), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_irq", 32'(irq), 32'h0);
    abort = 1; step();
    pulse_start();
    run_bits(KB, 1);
    finish_done(rand163(), rand163());

    // Reset during WAIT_DONE, then top-word readback of zout.
    load_key(rand163());
    pulse_start();
    run_bits(KB, 0);
    step(); step();
    rst = 1; step();
    rst = 0;
    check("rst_mid_ena", 32'(core_ena), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    step();
    load_key(rand163());
    pulse_start();
    run_bits(KB, 0);
    z = rand163(); z[KB-1 -: 3] = 3'b101;
    finish_done(rand163(), z);
    rd_rand = 0;
    rd_addr = 4'd11; step();
    check("rd_z5", rd_data, 32'h5);
    rd_addr = 4'd13; step();
    check("rd_oob", rd_data, 32'h0);
    rd_rand = 1;

    // Random runs: stray addresses, variable length, optional simultaneous done + last bit.
    for (int r = 0; r < 8; r++) begin
      write_word($urandom_range(6, 7), $urandom);
      load_key(rand163());
      pulse_start();
      n = $urandom_range(150, KB);
      run_bits(n - 1, 1);
      next_key = 1; core_done = 1'($urandom_range(0, 1));
      wout = rand163(); zout = rand163();
      step();
      for (int c = 0; c < 4 && busy; c++) begin
        if (c == 3) begin
          wout = rand163(); zout = rand163(); core_done = 1;
        end else begin
          next_key = 1'($urandom_range(0, 1));
        end
        step();
      end
      step(); step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
